// File: rtl/demux_pkg.sv
// Shared types and defaults for the demux1to7 serial distributor.
// Holds the controller state encoding and the default slot count.
package demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int SLOTS_DEFAULT = 7;

endpackage

// File: rtl/slot_counter.sv
// Auto-mode slot index counter; wraps to 0 after SLOTS-1.
// Ports: clock, reset (async, high), clr (sync clear, wins over en), en, count.
module slot_counter
    import demux_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count
);

    localparam logic [2:0] LAST = 3'(SLOTS - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? 3'd0 : count + 3'd1;
        end
    end

endmodule

// File: rtl/demux1to7.sv
// 1-to-SLOTS serial demux: manual addressed writes in IDLE, whole-frame
// collection into a shadow register in FILL, published to q on completion.
// Ports: clock, reset (async, high), d, we, sel, auto_mode ->
//        q (parallel slots), slot (next auto index), frame_done, sel_err.
module demux1to7
    import demux_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d,
    input  logic             we,
    input  logic [2:0]       sel,
    input  logic             auto_mode,
    output logic [SLOTS-1:0] q,
    output logic [2:0]       slot,
    output logic             frame_done,
    output logic             sel_err
);

    localparam logic [3:0] SLOTS_W = 4'(SLOTS);
    localparam logic [2:0] LAST    = 3'(SLOTS - 1);

    state_t           state, state_next;
    logic [SLOTS-1:0] shadow, shadow_next;
    logic [SLOTS-1:0] q_next;
    logic             done_next;
    logic             err_next;
    logic             cnt_clr;
    logic             cnt_en;
    logic             sel_ok;

    assign sel_ok = ({1'b0, sel} < SLOTS_W);

    slot_counter #(
        .SLOTS (SLOTS)
    ) u_slot_counter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (slot)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            q          <= '0;
            shadow     <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            state      <= state_next;
            q          <= q_next;
            shadow     <= shadow_next;
            frame_done <= done_next;
            sel_err    <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        q_next      = q;
        shadow_next = shadow;
        done_next   = 1'b0;
        err_next    = sel_err;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        unique case (state)
            IDLE: begin
                // Slot is pinned at 0 so FILL always starts a fresh frame;
                // the entry cycle still obeys manual-write rules.
                cnt_clr = 1'b1;
                if (auto_mode) begin
                    state_next = FILL;
                end
                if (we) begin
                    if (sel_ok) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            if (3'(i) == sel) begin
                                q_next[i] = d;
                            end
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            FILL: begin
                if (!auto_mode) begin
                    // Abort: the partial frame is dropped, q is untouched.
                    state_next  = IDLE;
                    cnt_clr     = 1'b1;
                    shadow_next = '0;
                end else if (we) begin
                    cnt_en = 1'b1;
                    for (int i = 0; i < SLOTS; i++) begin
                        if (3'(i) == slot) begin
                            shadow_next[i] = d;
                        end
                    end
                    if (slot == LAST) begin
                        q_next    = shadow_next;
                        done_next = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_demux1to7.sv
// Self-checking bench for demux1to7: vector table, corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_demux1to7;

    localparam int SLOTS = 7;

    logic       clock;
    logic       reset;
    logic       d;
    logic       we;
    logic [2:0] sel;
    logic       auto_mode;
    logic [6:0] q;
    logic [2:0] slot;
    logic       frame_done;
    logic       sel_err;

    int checks = 0;
    int errors = 0;

    demux1to7 #(.SLOTS(SLOTS)) dut (
        .clock      (clock),
        .reset      (reset),
        .d          (d),
        .we         (we),
        .sel        (sel),
        .auto_mode  (auto_mode),
        .q          (q),
        .slot       (slot),
        .frame_done (frame_done),
        .sel_err    (sel_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: frame collector expressed with plain arrays/ints.
    bit       m_fill;
    bit [6:0] m_q;
    bit [6:0] m_shadow;
    int       m_slot;
    bit       m_done;
    bit       m_err;

    task automatic model_reset();
        m_fill = 0; m_q = '0; m_shadow = '0;
        m_slot = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit am, input bit w,
                              input int s, input bit b);
        m_done = 0;
        if (!m_fill) begin
            if (w) begin
                if (s < SLOTS) m_q[s] = b;
                else m_err = 1;
            end
            m_slot = 0;
            m_fill = am;
        end else if (!am) begin
            m_fill = 0;
            m_slot = 0;
        end else if (w) begin
            m_shadow[m_slot] = b;
            m_slot = m_slot + 1;
            if (m_slot == SLOTS) begin
                m_q = m_shadow;
                m_slot = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit am, input bit w,
                       input logic [2:0] s, input bit b);
        auto_mode = am; we = w; sel = s; d = b;
        @(posedge clock);
        model_step(am, w, int'(s), b);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_q", 8'(q), 8'h00);
        chk("rst_slot", 8'(slot), 8'h00);
        chk("rst_done", 8'(frame_done), 8'h00);
        chk("rst_err", 8'(sel_err), 8'h00);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         am;
        bit         w;
        logic [2:0] s;
        bit         b;
        logic [6:0] eq;
        logic [2:0] es;
        bit         ed;
        bit         ee;
    } vec_t;

    vec_t       tbl[16];
    logic [6:0] fa, fb, pat;
    bit         am_r;

    initial begin
        reset = 1'b1; d = 0; we = 0; sel = '0; auto_mode = 0;
        model_reset();
        #12;
        chk("init_q", 8'(q), 8'h00);
        chk("init_slot", 8'(slot), 8'h00);
        chk("init_done", 8'(frame_done), 8'h00);
        chk("init_err", 8'(sel_err), 8'h00);
        @(negedge clock);
        reset = 1'b0;

        tbl[0]  = '{0, 1, 3'd3, 1, 7'b0001000, 3'd0, 0, 0};
        tbl[1]  = '{0, 1, 3'd6, 1, 7'b1001000, 3'd0, 0, 0};
        tbl[2]  = '{0, 1, 3'd7, 0, 7'b1001000, 3'd0, 0, 1};
        tbl[3]  = '{0, 0, 3'd0, 0, 7'b1001000, 3'd0, 0, 1};
        tbl[4]  = '{1, 0, 3'd0, 0, 7'b1001000, 3'd0, 0, 1};
        tbl[5]  = '{1, 1, 3'd7, 1, 7'b1001000, 3'd1, 0, 1};
        tbl[6]  = '{1, 0, 3'd0, 0, 7'b1001000, 3'd1, 0, 1};
        tbl[7]  = '{1, 1, 3'd0, 0, 7'b1001000, 3'd2, 0, 1};
        tbl[8]  = '{1, 1, 3'd0, 1, 7'b1001000, 3'd3, 0, 1};
        tbl[9]  = '{1, 0, 3'd0, 0, 7'b1001000, 3'd3, 0, 1};
        tbl[10] = '{1, 1, 3'd0, 1, 7'b1001000, 3'd4, 0, 1};
        tbl[11] = '{1, 1, 3'd0, 0, 7'b1001000, 3'd5, 0, 1};
        tbl[12] = '{1, 0, 3'd0, 0, 7'b1001000, 3'd5, 0, 1};
        tbl[13] = '{1, 1, 3'd0, 0, 7'b1001000, 3'd6, 0, 1};
        tbl[14] = '{1, 1, 3'd0, 1, 7'b1001101, 3'd0, 1, 1};
        tbl[15] = '{1, 0, 3'd0, 0, 7'b1001101, 3'd0, 0, 1};

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].am, tbl[i].w, tbl[i].s, tbl[i].b);
            chk($sformatf("tbl%0d_q", i), 8'(q), 8'(tbl[i].eq));
            chk($sformatf("tbl%0d_slot", i), 8'(slot), 8'(tbl[i].es));
            chk($sformatf("tbl%0d_done", i), 8'(frame_done), 8'(tbl[i].ed));
            chk($sformatf("tbl%0d_err", i), 8'(sel_err), 8'(tbl[i].ee));
        end

        // Sticky sel_err over idle cycles.
        for (int i = 0; i < 10; i++) cyc(0, 0, 3'd0, 0);
        chk("sticky_err", 8'(sel_err), 8'h01);
        chk("sticky_q", 8'(q), 8'(7'b1001101));

        // Async reset mid-frame, then no stray frame_done afterwards.
        cyc(1, 0, 3'd0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 3'd0, 1);
        chk("mid_slot", 8'(slot), 8'h05);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 3'd0, 0);
            chk("post_rst_done", 8'(frame_done), 8'h00);
        end
        chk("post_rst_q", 8'(q), 8'h00);

        // Back-to-back frames: entry edge 1, completions on edges 8 and 15.
        cyc(0, 0, 3'd0, 0);
        fa = 7'($urandom);
        fb = 7'($urandom);
        cyc(1, 0, 3'd0, 0);
        for (int k = 2; k <= 15; k++) begin
            if (k <= 8) cyc(1, 1, 3'd0, fa[k-2]);
            else cyc(1, 1, 3'd0, fb[k-9]);
            chk($sformatf("b2b_done%0d", k), 8'(frame_done),
                8'((k == 8) || (k == 15)));
            if (k >= 8 && k < 15) chk($sformatf("b2b_qa%0d", k), 8'(q), 8'(fa));
        end
        chk("b2b_qb", 8'(q), 8'(fb));
        chk("b2b_slot", 8'(slot), 8'h00);

        // Abort a partial frame, then publish only a fresh one.
        do_reset();
        cyc(1, 0, 3'd0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 1, 3'd0, 1);
        chk("abort_pre_q", 8'(q), 8'h7f);
        for (int i = 0; i < 4; i++) cyc(1, 1, 3'd0, 0);
        chk("abort_slot4", 8'(slot), 8'h04);
        cyc(0, 0, 3'd0, 0);
        chk("abort_q", 8'(q), 8'h7f);
        chk("abort_slot", 8'(slot), 8'h00);
        chk("abort_done", 8'(frame_done), 8'h00);
        cyc(1, 0, 3'd0, 0);
        pat = 7'b0101010;
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 3'd0, pat[i]);
            if (i < 6) chk("reentry_hold", 8'(q), 8'h7f);
        end
        chk("reentry_q", 8'(q), 8'(pat));
        chk("reentry_done", 8'(frame_done), 8'h01);

        // Randomized traffic against the reference model.
        do_reset();
        am_r = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 11) == 0) am_r = !am_r;
            cyc(am_r, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
            chk("rnd_q", 8'(q), 8'(m_q));
            chk("rnd_slot", 8'(slot), 8'(m_slot));
            chk("rnd_done", 8'(frame_done), 8'(m_done));
            chk("rnd_err", 8'(sel_err), 8'(m_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
